// File: rtl/instr_decode.sv
// RV32I decode/operand-issue stage: decodes one instruction per cycle into a registered control bundle.
// Define DECODE_SCOREBOARD_EN to enable the read-after-write busy scoreboard that stalls dependent issue.
module instr_decode #(
   parameter int XLEN       = 32,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  i_Clk,
   input  logic                  i_Rst,
   input  logic                  i_Valid,
   output logic                  o_Ready,
   input  logic [31:0]           i_Instr,
   input  logic [XLEN-1:0]       i_PC,
   input  logic                  i_Flush,
   output logic [REG_ADDR_W-1:0] o_Addr1,
   output logic [REG_ADDR_W-1:0] o_Addr2,
   output logic                  o_Valid,
   input  logic                  i_Ready,
   output logic [XLEN-1:0]       o_PC,
   output logic [REG_ADDR_W-1:0] o_Rd,
   output logic [31:0]           o_Imm,
   output logic [3:0]            o_AluOp,
   output logic                  o_AluSrcA,
   output logic                  o_AluSrcB,
   output logic                  o_WE,
   output logic [1:0]            o_WDSrc,
   output logic                  o_MemRead,
   output logic                  o_MemWrite,
   output logic [2:0]            o_Funct3,
   output logic                  o_Branch,
   output logic                  o_Jump,
   output logic                  o_JumpReg,
   output logic                  o_Illegal,
   input  logic                  i_WbValid,
   input  logic [REG_ADDR_W-1:0] i_WbAddr
);

   localparam int NREG = 2 ** REG_ADDR_W;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                          ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                          ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] rd;
      logic [REG_ADDR_W-1:0] rs1;
      logic [REG_ADDR_W-1:0] rs2;
      logic [31:0]           imm;
      logic [3:0]            alu_op;
      logic                  src_a;
      logic                  src_b;
      logic                  we;
      logic [1:0]            wd_src;
      logic                  mem_read;
      logic                  mem_write;
      logic [2:0]            funct3;
      logic                  branch;
      logic                  jump;
      logic                  jump_reg;
      logic                  illegal;
   } bundle_t;

   function automatic logic [3:0] alu_from_funct(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  alu_from_funct = alt ? ALU_SUB : ALU_ADD;
         3'b001:  alu_from_funct = ALU_SLL;
         3'b010:  alu_from_funct = ALU_SLT;
         3'b011:  alu_from_funct = ALU_SLTU;
         3'b100:  alu_from_funct = ALU_XOR;
         3'b101:  alu_from_funct = alt ? ALU_SRA : ALU_SRL;
         3'b110:  alu_from_funct = ALU_OR;
         default: alu_from_funct = ALU_AND;
      endcase
   endfunction

   // rd/rs fields are only populated for formats that use them, so unused ones read as x0
   function automatic bundle_t decode(input logic [31:0] ins);
      bundle_t b;
      logic [REG_ADDR_W-1:0] f_rd, f_rs1, f_rs2;
      logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
      f_rd  = REG_ADDR_W'(ins[11:7]);
      f_rs1 = REG_ADDR_W'(ins[19:15]);
      f_rs2 = REG_ADDR_W'(ins[24:20]);
      imm_i = {{20{ins[31]}}, ins[31:20]};
      imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      imm_u = {ins[31:12], 12'b0};
      imm_j = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      b = '0;
      b.funct3 = ins[14:12];
      case (ins[6:0])
         OPC_LUI:    begin b.rd = f_rd; b.imm = imm_u; b.alu_op = ALU_PASSB; b.src_b = 1'b1; b.we = 1'b1; end
         OPC_AUIPC:  begin b.rd = f_rd; b.imm = imm_u; b.src_a = 1'b1; b.src_b = 1'b1; b.we = 1'b1; end
         OPC_JAL:    begin b.rd = f_rd; b.imm = imm_j; b.src_a = 1'b1; b.src_b = 1'b1; b.we = 1'b1;
                           b.wd_src = 2'd2; b.jump = 1'b1; end
         OPC_JALR:   begin b.rd = f_rd; b.rs1 = f_rs1; b.imm = imm_i; b.src_b = 1'b1; b.we = 1'b1;
                           b.wd_src = 2'd2; b.jump_reg = 1'b1; end
         OPC_BRANCH: begin b.rs1 = f_rs1; b.rs2 = f_rs2; b.imm = imm_b; b.alu_op = ALU_SUB; b.branch = 1'b1; end
         OPC_LOAD:   begin b.rd = f_rd; b.rs1 = f_rs1; b.imm = imm_i; b.src_b = 1'b1; b.we = 1'b1;
                           b.wd_src = 2'd1; b.mem_read = 1'b1; end
         OPC_STORE:  begin b.rs1 = f_rs1; b.rs2 = f_rs2; b.imm = imm_s; b.src_b = 1'b1; b.mem_write = 1'b1; end
         OPC_OPIMM:  begin b.rd = f_rd; b.rs1 = f_rs1; b.imm = imm_i; b.src_b = 1'b1; b.we = 1'b1;
                           b.alu_op = alu_from_funct(ins[14:12], ins[30] && (ins[14:12] == 3'b101)); end
         OPC_OP:     begin b.rd = f_rd; b.rs1 = f_rs1; b.rs2 = f_rs2; b.we = 1'b1;
                           b.alu_op = alu_from_funct(ins[14:12], ins[30]); end
         OPC_FENCE:  b.funct3 = ins[14:12];
         default:    begin b.illegal = 1'b1; b.funct3 = ins[14:12]; end
      endcase
      if (b.rd == '0) b.we = 1'b0;
      return b;
   endfunction

   bundle_t         dec;
   bundle_t         bnd_p1;
   logic [XLEN-1:0] pc_p1;
   logic            vld_p1;
   logic            hazard;
   logic            accept;

   always_comb dec = decode(i_Instr);

   assign o_Ready = (!vld_p1 || i_Ready) && !hazard;
   assign accept  = i_Valid && o_Ready && !i_Flush;

`ifdef DECODE_SCOREBOARD_EN
   logic [NREG-1:0] busy_q;
   logic [NREG-1:0] busy_d;

   // A writeback in this cycle lands on the same edge as the read, so it cannot clear a hazard yet
   always_comb begin
      hazard = i_Valid && (((dec.rs1 != '0) && busy_q[dec.rs1]) ||
                           ((dec.rs2 != '0) && busy_q[dec.rs2]));
   end

   always_comb begin
      busy_d = busy_q;
      if (i_WbValid) busy_d[i_WbAddr] = 1'b0;
      if (accept && dec.we) busy_d[dec.rd] = 1'b1;
   end

   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) busy_q <= '0;
      else       busy_q <= busy_d;
   end
`else
   logic unused_wb;
   assign hazard    = 1'b0;
   assign unused_wb = ^{i_WbValid, i_WbAddr, NREG[0]};
`endif

   // p0 -> p1: decoded bundle registered to align with register-file read data
   always_ff @(posedge i_Clk or posedge i_Rst) begin
      if (i_Rst) begin
         vld_p1 <= 1'b0;
         bnd_p1 <= '0;
         pc_p1  <= '0;
      end else if (i_Flush) begin
         vld_p1 <= 1'b0;
      end else if (accept) begin
         vld_p1 <= 1'b1;
         bnd_p1 <= dec;
         pc_p1  <= i_PC;
      end else if (i_Ready) begin
         vld_p1 <= 1'b0;
      end
   end

   assign o_Addr1    = accept ? dec.rs1 : bnd_p1.rs1;
   assign o_Addr2    = accept ? dec.rs2 : bnd_p1.rs2;
   assign o_Valid    = vld_p1;
   assign o_PC       = pc_p1;
   assign o_Rd       = bnd_p1.rd;
   assign o_Imm      = bnd_p1.imm;
   assign o_AluOp    = bnd_p1.alu_op;
   assign o_AluSrcA  = bnd_p1.src_a;
   assign o_AluSrcB  = bnd_p1.src_b;
   assign o_WE       = bnd_p1.we;
   assign o_WDSrc    = bnd_p1.wd_src;
   assign o_MemRead  = bnd_p1.mem_read;
   assign o_MemWrite = bnd_p1.mem_write;
   assign o_Funct3   = bnd_p1.funct3;
   assign o_Branch   = bnd_p1.branch;
   assign o_Jump     = bnd_p1.jump;
   assign o_JumpReg  = bnd_p1.jump_reg;
   assign o_Illegal  = bnd_p1.illegal;

endmodule

// File: tb/tb_instr_decode.sv
// Scoreboard bench for instr_decode: directed vectors push expected bundles; a monitor checks each handshake.
module tb_instr_decode;

   logic        i_Clk, i_Rst, i_Valid, o_Ready, i_Flush, i_Ready;
   logic [31:0] i_Instr, i_PC, o_PC, o_Imm;
   logic [4:0]  o_Addr1, o_Addr2, o_Rd, i_WbAddr;
   logic        o_Valid, o_AluSrcA, o_AluSrcB, o_WE, o_MemRead, o_MemWrite;
   logic        o_Branch, o_Jump, o_JumpReg, o_Illegal, i_WbValid;
   logic [3:0]  o_AluOp;
   logic [1:0]  o_WDSrc;
   logic [2:0]  o_Funct3;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        sa, sb, we;
      logic [1:0]  wd;
      logic        mr, mw;
      logic [2:0]  f3;
      logic        br, j, jr, ill;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   w;

   instr_decode #(.XLEN(32), .REG_ADDR_W(5)) dut (
      .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Valid(i_Valid), .o_Ready(o_Ready), .i_Instr(i_Instr),
      .i_PC(i_PC), .i_Flush(i_Flush), .o_Addr1(o_Addr1), .o_Addr2(o_Addr2), .o_Valid(o_Valid),
      .i_Ready(i_Ready), .o_PC(o_PC), .o_Rd(o_Rd), .o_Imm(o_Imm), .o_AluOp(o_AluOp),
      .o_AluSrcA(o_AluSrcA), .o_AluSrcB(o_AluSrcB), .o_WE(o_WE), .o_WDSrc(o_WDSrc),
      .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_Funct3(o_Funct3), .o_Branch(o_Branch),
      .o_Jump(o_Jump), .o_JumpReg(o_JumpReg), .o_Illegal(o_Illegal), .i_WbValid(i_WbValid),
      .i_WbAddr(i_WbAddr)
   );

   initial i_Clk = 1'b0;
   always #5 i_Clk = ~i_Clk;

   function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] imm,
                               input logic [3:0] alu, input logic sa, input logic sb, input logic we,
                               input logic [1:0] wd, input logic mr, input logic mw,
                               input logic [2:0] f3, input logic br, input logic j,
                               input logic jr, input logic ill);
      mk = {pc, rd, imm, alu, sa, sb, we, wd, mr, mw, f3, br, j, jr, ill};
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   always @(negedge i_Clk) begin
      exp_t a, e;
      if (!i_Rst && o_Valid && i_Ready) begin
         a = {o_PC, o_Rd, o_Imm, o_AluOp, o_AluSrcA, o_AluSrcB, o_WE, o_WDSrc, o_MemRead,
              o_MemWrite, o_Funct3, o_Branch, o_Jump, o_JumpReg, o_Illegal};
         if (q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_bundle: got pc %h rd %0d, expected no bundle", o_PC, o_Rd);
         end else begin
            e = q.pop_front();
            check($sformatf("bundle pc=%h", e.pc), a, e);
         end
      end
   end

   task automatic send(input logic [31:0] ins, input exp_t e, input logic [4:0] a1,
                       input logic [4:0] a2, input bit push, output int waited);
      bit ok;
      ok = 1'b0;
      waited = 0;
      i_Valid = 1'b1;
      i_Instr = ins;
      i_PC = e.pc;
      while (!ok && waited < 40) begin
         @(negedge i_Clk);
         if (o_Ready) begin
            ok = 1'b1;
            check($sformatf("addr1 pc=%h", e.pc), o_Addr1, a1);
            check($sformatf("addr2 pc=%h", e.pc), o_Addr2, a2);
            if (push) q.push_back(e);
         end else begin
            waited++;
         end
         @(posedge i_Clk); #1;
      end
      i_Valid = 1'b0;
      if (!ok) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout pc=%h: got no accept, expected accept", e.pc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge i_Clk); #1; end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      i_Rst = 1'b1; i_Valid = 1'b0; i_Instr = '0; i_PC = '0; i_Flush = 1'b0;
      i_Ready = 1'b0; i_WbValid = 1'b0; i_WbAddr = '0;
      #2;
      check("reset_valid", o_Valid, 1'b0);
      check("reset_imm", o_Imm, 32'h0);
      check("reset_ready", o_Ready, 1'b1);
      idle(2);
      i_Rst = 1'b0;
      i_Ready = 1'b1;

      // pc, rd, imm, alu, sa, sb, we, wd, mr, mw, f3, br, j, jr, ill
      send(32'hFFD08293, mk(32'h100, 5'd5,  32'hFFFFFFFD, 4'd0,  0,1,1,2'd0,0,0,3'd0,0,0,0,0), 5'd1, 5'd0, 1, w);
      send(32'h12345537, mk(32'h104, 5'd10, 32'h12345000, 4'd10, 0,1,1,2'd0,0,0,3'd5,0,0,0,0), 5'd0, 5'd0, 1, w);
      send(32'h00001597, mk(32'h108, 5'd11, 32'h00001000, 4'd0,  1,1,1,2'd0,0,0,3'd1,0,0,0,0), 5'd0, 5'd0, 1, w);
      send(32'h0020A623, mk(32'h10C, 5'd0,  32'h0000000C, 4'd0,  0,1,0,2'd0,0,1,3'd2,0,0,0,0), 5'd1, 5'd2, 1, w);
      send(32'hFE208EE3, mk(32'h110, 5'd0,  32'hFFFFFFFC, 4'd1,  0,0,0,2'd0,0,0,3'd0,1,0,0,0), 5'd1, 5'd2, 1, w);
      send(32'h40425493, mk(32'h114, 5'd9,  32'h00000404, 4'd7,  0,1,1,2'd0,0,0,3'd5,0,0,0,0), 5'd4, 5'd0, 1, w);
      send(32'h00808667, mk(32'h118, 5'd12, 32'h00000008, 4'd0,  0,1,1,2'd2,0,0,3'd0,0,0,1,0), 5'd1, 5'd0, 1, w);
      send(32'h0080006F, mk(32'h11C, 5'd0,  32'h00000008, 4'd0,  1,1,0,2'd2,0,0,3'd0,0,1,0,0), 5'd0, 5'd0, 1, w);
      send(32'h00000073, mk(32'h120, 5'd0,  32'h00000000, 4'd0,  0,0,0,2'd0,0,0,3'd0,0,0,0,1), 5'd0, 5'd0, 1, w);
      send(32'h0FF0000F, mk(32'h124, 5'd0,  32'h00000000, 4'd0,  0,0,0,2'd0,0,0,3'd0,0,0,0,0), 5'd0, 5'd0, 1, w);
      idle(1);

      // execute back-pressure holds SUB x3,x1,x2
      i_Ready = 1'b0;
      send(32'h402081B3, mk(32'h200, 5'd3, 32'h0, 4'd1, 0,0,1,2'd0,0,0,3'd0,0,0,0,0), 5'd1, 5'd2, 1, w);
      for (int k = 0; k < 3; k++) begin
         @(negedge i_Clk);
         check("hold_valid", o_Valid, 1'b1);
         check("hold_rd", o_Rd, 5'd3);
         check("hold_aluop", o_AluOp, 4'd1);
         check("hold_addr1", o_Addr1, 5'd1);
         check("hold_addr2", o_Addr2, 5'd2);
         check("hold_ready", o_Ready, 1'b0);
         @(posedge i_Clk); #1;
      end
      i_Ready = 1'b1;
      idle(1);

      // flush kills the held ADDI x13 and the incoming LUI
      i_Ready = 1'b0;
      send(32'h00700693, mk(32'h300, 5'd13, 32'h7, 4'd0, 0,1,1,2'd0,0,0,3'd0,0,0,0,0), 5'd0, 5'd0, 0, w);
      i_Valid = 1'b1; i_Instr = 32'h12345537; i_PC = 32'h304; i_Flush = 1'b1;
      @(posedge i_Clk); #1;
      i_Flush = 1'b0; i_Valid = 1'b0;
      @(negedge i_Clk);
      check("flush_valid", o_Valid, 1'b0);
      @(posedge i_Clk); #1;
      check("flush_no_accept", o_Valid, 1'b0);
      i_Ready = 1'b1;
      idle(2);

      // LW x6 then dependent ADD x7,x6,x6
      send(32'h00412303, mk(32'h400, 5'd6, 32'h4, 4'd0, 0,1,1,2'd1,1,0,3'd2,0,0,0,0), 5'd2, 5'd0, 1, w);
`ifdef DECODE_SCOREBOARD_EN
      i_Valid = 1'b1; i_Instr = 32'h006303B3; i_PC = 32'h404;
      for (int k = 0; k < 3; k++) begin
         @(negedge i_Clk);
         check("raw_stall", o_Ready, 1'b0);
         @(posedge i_Clk); #1;
      end
      i_WbValid = 1'b1; i_WbAddr = 5'd6;
      @(negedge i_Clk);
      check("raw_stall_wb_cycle", o_Ready, 1'b0);
      @(posedge i_Clk); #1;
      i_WbValid = 1'b0; i_WbAddr = 5'd0;
      i_Valid = 1'b0;
`endif
      send(32'h006303B3, mk(32'h404, 5'd7, 32'h0, 4'd0, 0,0,1,2'd0,0,0,3'd0,0,0,0,0), 5'd6, 5'd6, 1, w);
      check("raw_release_wait", w, 0);

      // writes to x0 never create a dependency
      send(32'h00100013, mk(32'h500, 5'd0, 32'h1, 4'd0, 0,1,0,2'd0,0,0,3'd0,0,0,0,0), 5'd0, 5'd0, 1, w);
      send(32'h00000433, mk(32'h504, 5'd8, 32'h0, 4'd0, 0,0,1,2'd0,0,0,3'd0,0,0,0,0), 5'd0, 5'd0, 1, w);
      check("x0_no_stall", w, 0);
      idle(2);

      // asynchronous reset while a bundle is held
      i_Ready = 1'b0;
      send(32'hFFD08293, mk(32'h600, 5'd5, 32'hFFFFFFFD, 4'd0, 0,1,1,2'd0,0,0,3'd0,0,0,0,0), 5'd1, 5'd0, 0, w);
      check("pre_reset_valid", o_Valid, 1'b1);
      @(negedge i_Clk);
      i_Rst = 1'b1;
      #1;
      check("async_reset_valid", o_Valid, 1'b0);
      check("async_reset_imm", o_Imm, 32'h0);
      @(posedge i_Clk); #1;
      i_Rst = 1'b0;
      i_Ready = 1'b1;
      idle(2);
      check("queue_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
